// File: rtl/con_pkg.sv
// Shared condition-code definitions for the Mini-SRC condition-flag bank.
package con_pkg;

   typedef logic [2:0] con_code_t;

   localparam con_code_t CON_EQ     = 3'b000;
   localparam con_code_t CON_NE     = 3'b001;
   localparam con_code_t CON_GE     = 3'b010;
   localparam con_code_t CON_LT     = 3'b011;
   localparam con_code_t CON_GT     = 3'b100;
   localparam con_code_t CON_LE     = 3'b101;
   localparam con_code_t CON_ALWAYS = 3'b110;
   localparam con_code_t CON_NEVER  = 3'b111;

endpackage

// File: rtl/con_eval.sv
// Combinational condition evaluator: tests the bus against zero, or a latched
// operand A against the bus using a signed difference that cannot overflow.
module con_eval
   import con_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_compareMode,
   input  con_code_t        i_code,
   output logic             o_result
);

   logic [WIDTH:0] w_diff;
   logic           w_neg;
   logic           w_zero;

   // One extra sign bit keeps A - B exact for every pair of signed operands.
   assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
   assign w_neg  = i_compareMode ? w_diff[WIDTH] : i_b[WIDTH-1];
   assign w_zero = i_compareMode ? (w_diff == '0) : (i_b == '0);

   always_comb begin
      o_result = 1'b0;
      case (i_code)
         CON_EQ:     o_result = w_zero;
         CON_NE:     o_result = ~w_zero;
         CON_GE:     o_result = ~w_neg;
         CON_LT:     o_result = w_neg;
         CON_GT:     o_result = ~w_neg & ~w_zero;
         CON_LE:     o_result = w_neg | w_zero;
         CON_ALWAYS: o_result = 1'b1;
         default:    o_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/con_ff_bank.sv
// Bank of predicate flags written from condition evaluations, with operand-A
// latch, optional commit pipeline stage, sticky error and taken counter.
module con_ff_bank
   import con_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_FLAGS = 4,
   parameter int PIPE      = 0,
   parameter int CNT_W     = 16,
   localparam int SEL_W    = $clog2(NUM_FLAGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] in_bus,
   input  logic [2:0]       in_condition,
   input  logic             in_compare_mode,
   input  logic [SEL_W-1:0] in_flag_sel,
   input  logic             in_op_latch,
   input  logic             in_con_write,
   input  logic             in_stat_clr,
   output logic             out_branch,
   output logic [NUM_FLAGS-1:0] out_flags,
   output logic             out_a_valid,
   output logic             out_busy,
   output logic             out_err,
   output logic [CNT_W-1:0] out_taken_count
);

   logic [WIDTH-1:0]     r_opA;
   logic                 r_aValid;
   logic [NUM_FLAGS-1:0] r_flags;
   logic                 r_err;
   logic [CNT_W-1:0]     r_count;

   logic             w_result;
   logic             w_aMissing;
   logic             w_accept;
   logic             w_commitEn;
   logic [SEL_W-1:0] w_commitIdx;
   logic             w_commitVal;

   con_eval #(.WIDTH(WIDTH)) u_eval (
      .i_a           (r_opA),
      .i_b           (in_bus),
      .i_compareMode (in_compare_mode),
      .i_code        (con_code_t'(in_condition)),
      .o_result      (w_result)
   );

   // A compare-mode write is only legal while operand A is held.
   assign w_aMissing = in_compare_mode & ~r_aValid;
   assign w_accept   = in_con_write & ~w_aMissing;

   // A same-cycle latch wins over consumption; evaluation still sees the old A.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_opA    <= '0;
         r_aValid <= 1'b0;
      end else if (in_op_latch) begin
         r_opA    <= in_bus;
         r_aValid <= 1'b1;
      end else if (in_con_write && in_compare_mode) begin
         r_aValid <= 1'b0;
      end
   end

   generate
      if (PIPE != 0) begin : g_pipe
         logic             r_pValid;
         logic [SEL_W-1:0] r_pIdx;
         logic             r_pVal;

         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               r_pValid <= 1'b0;
               r_pIdx   <= '0;
               r_pVal   <= 1'b0;
            end else begin
               r_pValid <= w_accept;
               r_pIdx   <= in_flag_sel;
               r_pVal   <= w_result;
            end
         end

         assign w_commitEn  = r_pValid;
         assign w_commitIdx = r_pIdx;
         assign w_commitVal = r_pVal;
         assign out_busy    = r_pValid;
      end else begin : g_direct
         assign w_commitEn  = w_accept;
         assign w_commitIdx = in_flag_sel;
         assign w_commitVal = w_result;
         assign out_busy    = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_flags <= '0;
      end else if (w_commitEn) begin
         r_flags[w_commitIdx] <= w_commitVal;
      end
   end

   // Statistics clear takes priority over both the error set and a count.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_err   <= 1'b0;
         r_count <= '0;
      end else if (in_stat_clr) begin
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         if (in_con_write && w_aMissing) begin
            r_err <= 1'b1;
         end
         if (w_commitEn && w_commitVal && !(&r_count)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign out_branch      = r_flags[in_flag_sel];
   assign out_flags       = r_flags;
   assign out_a_valid     = r_aValid;
   assign out_err         = r_err;
   assign out_taken_count = r_count;

endmodule

// File: tb/tb_con_ff_bank.sv
// Directed bench: a PIPE=0 instance for the functional scenarios and a PIPE=1,
// CNT_W=2 instance for pipelining, saturation and asynchronous clear.
module tb_con_ff_bank;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] inBus = '0;
   logic [2:0]  inCondition = '0;
   logic        inCompareMode = 1'b0;
   logic [1:0]  inFlagSel = '0;
   logic        inOpLatch = 1'b0;
   logic        inConWrite = 1'b0;
   logic        inStatClr = 1'b0;

   logic        branch0, aValid0, busy0, err0;
   logic [3:0]  flags0;
   logic [15:0] count0;
   logic        branch1, aValid1, busy1, err1;
   logic [3:0]  flags1;
   logic [1:0]  count1;

   int testsRun = 0;
   int testsFailed = 0;

   con_ff_bank u_dut0 (
      .clk(clk), .clr(clr), .in_bus(inBus), .in_condition(inCondition),
      .in_compare_mode(inCompareMode), .in_flag_sel(inFlagSel),
      .in_op_latch(inOpLatch), .in_con_write(inConWrite), .in_stat_clr(inStatClr),
      .out_branch(branch0), .out_flags(flags0), .out_a_valid(aValid0),
      .out_busy(busy0), .out_err(err0), .out_taken_count(count0)
   );

   con_ff_bank #(.PIPE(1), .CNT_W(2)) u_dut1 (
      .clk(clk), .clr(clr), .in_bus(inBus), .in_condition(inCondition),
      .in_compare_mode(inCompareMode), .in_flag_sel(inFlagSel),
      .in_op_latch(inOpLatch), .in_con_write(inConWrite), .in_stat_clr(inStatClr),
      .out_branch(branch1), .out_flags(flags1), .out_a_valid(aValid1),
      .out_busy(busy1), .out_err(err1), .out_taken_count(count1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic latch, input logic write, input logic mode,
                                input logic [2:0] cond, input logic [1:0] sel,
                                input logic [31:0] bus);
      inOpLatch     = latch;
      inConWrite    = write;
      inCompareMode = mode;
      inCondition   = cond;
      inFlagSel     = sel;
      inBus         = bus;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b111, 2'd0, 32'h0);
      inStatClr = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      testsRun++;
      if ({flags0, branch0, aValid0, busy0, err0, count0} !== 20'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_pipe0: got flags=%b br=%b av=%b busy=%b err=%b cnt=%0d expected all 0",
                  flags0, branch0, aValid0, busy0, err0, count0);
      end
      testsRun++;
      if ({flags1, branch1, aValid1, busy1, err1, count1} !== 10'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_pipe1: got flags=%b busy=%b cnt=%0d expected all 0", flags1, busy1, count1);
      end
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_zero_mode();
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0000);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b011, 2'd1, 32'h8000_0000);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b101, 2'd2, 32'h0000_0005);
      tick();
      idle();
      inFlagSel = 2'd1;
      #1;
      testsRun++;
      if (flags0 !== 4'b0011) begin
         testsFailed++;
         $display("[TB] FAIL zero_flags: got %b expected %b", flags0, 4'b0011);
      end
      testsRun++;
      if (count0 !== 16'd2) begin
         testsFailed++;
         $display("[TB] FAIL zero_count: got %0d expected 2", count0);
      end
      testsRun++;
      if (branch0 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL zero_branch_sel1: got %b expected 1", branch0);
      end
      inFlagSel = 2'd2;
      #1;
      testsRun++;
      if (branch0 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL zero_branch_sel2: got %b expected 0", branch0);
      end
   endtask

   task automatic test_compare();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 2'd0, 32'hFFFF_FFFD);
      tick();
      testsRun++;
      if (aValid0 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL cmp_latch_valid: got %b expected 1", aValid0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b011, 2'd3, 32'h0000_0004);
      tick();
      testsRun++;
      if (flags0 !== 4'b1011 || aValid0 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL cmp_lt: got flags=%b av=%b expected flags=1011 av=0", flags0, aValid0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 2'd0, 32'h7FFF_FFFF);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b100, 2'd2, 32'h8000_0000);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 2'd0, 32'h0000_0005);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b100, 2'd0, 32'h0000_0005);
      tick();
      idle();
      testsRun++;
      if (flags0 !== 4'b1110 || count0 !== 16'd4) begin
         testsFailed++;
         $display("[TB] FAIL cmp_gt_pair: got flags=%b cnt=%0d expected flags=1110 cnt=4", flags0, count0);
      end
   endtask

   task automatic test_error();
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b110, 2'd0, 32'h0000_0001);
      tick();
      idle();
      testsRun++;
      if (flags0 !== 4'b1110 || count0 !== 16'd4 || err0 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL err_no_a: got flags=%b cnt=%0d err=%b expected flags=1110 cnt=4 err=1",
                  flags0, count0, err0);
      end
      inStatClr = 1'b1;
      tick();
      idle();
      testsRun++;
      if (err0 !== 1'b0 || count0 !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL stat_clr: got err=%b cnt=%0d expected err=0 cnt=0", err0, count0);
      end
   endtask

   task automatic test_same_cycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 2'd0, 32'd7);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 32'd7);
      tick();
      testsRun++;
      if (flags0 !== 4'b1111 || aValid0 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL same_eq: got flags=%b av=%b expected flags=1111 av=1", flags0, aValid0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 32'd9);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 2'd3, 32'd9);
      tick();
      idle();
      testsRun++;
      if (flags0 !== 4'b1101 || aValid0 !== 1'b0 || count0 !== 16'd2) begin
         testsFailed++;
         $display("[TB] FAIL same_old_a: got flags=%b av=%b cnt=%0d expected flags=1101 av=0 cnt=2",
                  flags0, aValid0, count0);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] expFlags [0:4];
      logic [1:0] expCount [0:4];
      expFlags = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      expCount = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      clr = 1'b1;
      #2;
      clr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) applyStimulus(1'b0, 1'b1, 1'b0, 3'b110, k[1:0], 32'h0);
         else idle();
         tick();
         testsRun++;
         if (flags1 !== expFlags[k] || count1 !== expCount[k] || busy1 !== (k < 4)) begin
            testsFailed++;
            $display("[TB] FAIL pipe_step%0d: got flags=%b cnt=%0d busy=%b expected flags=%b cnt=%0d busy=%b",
                     k, flags1, count1, busy1, expFlags[k], expCount[k], (k < 4));
         end
      end
      inFlagSel = 2'd2;
      #1;
      testsRun++;
      if (branch1 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL pipe_branch: got %b expected 1", branch1);
      end
   endtask

   task automatic test_clr_midstream();
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b111, 2'd0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b110, 2'd0, 32'h0);
      #2;
      clr = 1'b1;
      #1;
      testsRun++;
      if ({flags1, branch1, busy1, count1} !== 8'h0 || {flags0, count0, err0, aValid0} !== 22'h0) begin
         testsFailed++;
         $display("[TB] FAIL clr_async: got flags1=%b busy1=%b cnt1=%0d flags0=%b cnt0=%0d expected all 0",
                  flags1, busy1, count1, flags0, count0);
      end
      idle();
      #1;
      clr = 1'b0;
      tick();
      tick();
      testsRun++;
      if (flags1 !== 4'b0000 || busy1 !== 1'b0 || count1 !== 2'd0) begin
         testsFailed++;
         $display("[TB] FAIL clr_discard: got flags=%b busy=%b cnt=%0d expected 0000 0 0", flags1, busy1, count1);
      end
   endtask

   initial begin
      test_reset();
      test_zero_mode();
      test_compare();
      test_error();
      test_same_cycle();
      test_back_to_back();
      test_clr_midstream();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/con_ff_bank.md
# con_ff_bank

Parametrised condition-flag unit for the Mini-SRC datapath; the next generation of the single-bit CON flip-flop. Evaluates one of eight conditions on the bus value, either against zero or against a previously latched operand, and writes the result into one of NUM_FLAGS predicate flags. The control unit reads the selected flag as the branch decision. An optional pipeline stage and a saturating taken-branch counter are included.

## Interface
- WIDTH, 32, bus/operand width (≥2)
- NUM_FLAGS, 4, number of predicate flags (≥2, power of two)
- PIPE, 0, 0 = flag written on the evaluate edge; 1 = one extra register stage
- CNT_W, 16, taken-counter width
- clk  in  1  clock, all state rising-edge
- clr  in  1  reset, asynchronous, active-high
- in_bus  in  WIDTH  bus value (operand B, or operand A when latching)
- in_condition  in  3  condition code
- in_compare_mode  in  1  0 = compare bus vs zero; 1 = compare latched A vs bus
- in_flag_sel  in  log2(NUM_FLAGS)  write target on evaluate; read index for out_branch
- in_op_latch  in  1  latch in_bus into operand A
- in_con_write  in  1  evaluate and write selected flag
- in_stat_clr  in  1  synchronous clear of counter and error
- out_branch  out  1  flags[in_flag_sel], combinational read
- out_flags  out  NUM_FLAGS  all flags
- out_a_valid  out  1  operand A held
- out_busy  out  1  PIPE=1 write in flight
- out_err  out  1  sticky: compare-mode write without valid A
- out_taken_count  out  CNT_W  saturating count of writes producing 1

## Operation
- Codes: 000 EQ, 001 NE, 010 GE, 011 LT, 100 GT, 101 LE (all two's-complement signed), 110 ALWAYS (1), 111 NEVER (0).
- Zero mode: X = in_bus vs 0; GE/LT use bit WIDTH-1 only; GT = ~sign & nonzero; LE = sign | zero.
- Compare mode: X = A − in_bus computed in WIDTH+1 bits with sign extension (no overflow); EQ on zero difference, signs from bit WIDTH.
- in_op_latch: A ← in_bus, a_valid ← 1.
- Compare-mode write consumes A: a_valid ← 0, unless in_op_latch in the same cycle (then A ← new bus, a_valid stays 1; evaluation uses old A).
- Compare-mode write with a_valid = 0: flag unchanged, counter unchanged, out_err ← 1.
- Zero-mode write never touches A or a_valid.
- Counter increments on each committed write of 1, saturating at all-ones; in_stat_clr zeroes counter and out_err, and overrides an increment in the same cycle.
- Write to a flag never disturbs other flags.

## Timing
- Reset: flags 0, A 0, a_valid 0, out_busy 0, out_err 0, counter 0; out_branch therefore 0.
- PIPE=0: flag, counter, err update on the edge sampling in_con_write; visible the next cycle.
- PIPE=1: result and flag index registered on edge N, flag/counter committed on edge N+1; out_busy high between. Back-to-back writes accepted every cycle (fully pipelined); out_busy high while any write is in stage 2. err set at edge N. A consumption at edge N.
- out_branch is combinational from flags and in_flag_sel; no bypass of in-flight PIPE=1 results.
- clr mid-operation discards any in-flight stage-2 write.

## Structure
- Package con_pkg: condition-code localparams (CON_EQ … CON_NEVER), code typedef.
- Sub-module con_eval: combinational, params WIDTH; inputs A, B, compare_mode, code; output result. Top holds A, flags, pipe stage, counter, err.

## Test plan
- Reset then zero-mode writes: bus 0 EQ → flag0 = 1; bus 0x8000_0000 LT → flag1 = 1; bus 5 LE → flag2 = 0; out_taken_count = 2.
- Compare mode: latch A = −3 (0xFFFF_FFFD), write bus 4 LT → 1, a_valid 0 next cycle; A = 0x7FFF_FFFF vs bus 0x8000_0000 GT → 1 (no overflow error).
- Compare write with no valid A → flags unchanged, out_err = 1; in_stat_clr → out_err = 0, counter 0.
- Same-cycle latch + compare write: old A = 7, bus 7 EQ → 1; A becomes 7 with a_valid = 1.
- PIPE=1, CNT_W=2: four consecutive ALWAYS writes to flags 0–3 → each flag 1 one cycle after its write, out_busy high throughout, counter saturates at 3; clr asserted mid-stream → all outputs 0 asynchronously.
